// File: rtl/mem_arb_2p.sv
// Two-port arbiter for the 512x8 single-port RAM: port 0 has fixed priority, and a starvation counter forces port 1 through.
// Define MEM_ARB_ROUND_ROBIN_EN to arbitrate contention round-robin instead.
module mem_arb_2p #(
    parameter int AW        = 9,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_p0_req,
    input  logic          i_p0_we,
    input  logic [AW-1:0] i_p0_addr,
    input  logic [DW-1:0] i_p0_wdata,
    output logic          o_p0_gnt,
    output logic          o_p0_rvalid,
    output logic [DW-1:0] o_p0_rdata,
    input  logic          i_p1_req,
    input  logic          i_p1_we,
    input  logic [AW-1:0] i_p1_addr,
    input  logic [DW-1:0] i_p1_wdata,
    output logic          o_p1_gnt,
    output logic          o_p1_rvalid,
    output logic [DW-1:0] o_p1_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    logic          p0_gnt;
    logic          p1_gnt;
    logic          pick_p1;
    logic [AW-1:0] held_addr;
    logic [1:0]    rd_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_gnt_p1;

    // Remember who won last so the other port wins the next contended cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            last_gnt_p1 <= 1'b1;
        else if (p0_gnt || p1_gnt)
            last_gnt_p1 <= p1_gnt;
    end

    assign pick_p1 = ~last_gnt_p1;
`else
    logic [3:0] starve_cnt;

    // Count port 0 wins while port 1 waits; when it reaches MAX_BURST, port 1 wins the next contended cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            starve_cnt <= 4'd0;
        else if (p1_gnt || !i_p1_req)
            starve_cnt <= 4'd0;
        else if (p0_gnt && starve_cnt != 4'(MAX_BURST))
            starve_cnt <= starve_cnt + 4'd1;
    end

    assign pick_p1 = (starve_cnt == 4'(MAX_BURST));
`endif

    assign p0_gnt   = ~i_rst & i_p0_req & ~(i_p1_req & pick_p1);
    assign p1_gnt   = ~i_rst & i_p1_req & ~(i_p0_req & ~pick_p1);
    assign o_p0_gnt = p0_gnt;
    assign o_p1_gnt = p1_gnt;

    always_comb begin
        o_mem_addr  = i_rst ? '0 : held_addr;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        if (p0_gnt) begin
            o_mem_addr  = i_p0_addr;
            o_mem_we    = i_p0_we;
            o_mem_wdata = i_p0_wdata;
        end else if (p1_gnt) begin
            o_mem_addr  = i_p1_addr;
            o_mem_we    = i_p1_we;
            o_mem_wdata = i_p1_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            held_addr <= '0;
        else if (p0_gnt || p1_gnt)
            held_addr <= o_mem_addr;
    end

    // Track which port's read is coming back from the RAM next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            rd_owner <= 2'b00;
        else
            rd_owner <= {p1_gnt & ~i_p1_we, p0_gnt & ~i_p0_we};
    end

    // Gating with reset drops a read that was still in flight when reset arrived.
    assign o_p0_rvalid = rd_owner[0] & ~i_rst;
    assign o_p1_rvalid = rd_owner[1] & ~i_rst;
    assign o_p0_rdata  = o_p0_rvalid ? i_mem_rdata : '0;
    assign o_p1_rdata  = o_p1_rvalid ? i_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb_2p.sv
// Self-checking bench for mem_arb_2p: a behavioural write-first RAM plus a read-return scoreboard queue.
// The arbitration model follows MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arb_2p;
    localparam int AW        = 9;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] ram     [512];
    logic [DW-1:0] ref_mem [512];

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rd_t;
    rd_t rd_q[$];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   scnt     = 0;
    logic last_p1  = 1'b1;

    always #5 clk = ~clk;

    mem_arb_2p #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(ram_rdata)
    );

    // Behavioural RAM with registered, write-first read.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        ram_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        p0_req = 1'b1; p0_addr = 9'h005;
        @(negedge clk);
        n_checks++; if ({p1_gnt, p0_gnt} !== 2'b00) $display("[TB] FAIL reset_gnt: got %b expected 00", {p1_gnt, p0_gnt}); else n_pass++;
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 9'h000) $display("[TB] FAIL reset_mem: got we=%b addr=%h expected we=0 addr=000", mem_we, mem_addr); else n_pass++;
        n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== 18'h0) $display("[TB] FAIL reset_ret: got %h expected 0", {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}); else n_pass++;
        next_cycle();
        rst = 1'b0;
        set_idle();
        rd_q.delete();
        scnt = 0; last_p1 = 1'b1;
    endtask

    task automatic test_basic_rw();
        rd_t e;
        logic [17:0] exp_ret;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            set_idle();
            if (c == 0) begin p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h1F0; p0_wdata = 8'hA5; end
            if (c == 1) begin p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h1F0; end
            @(negedge clk);
            exp_ret = '0;
            if (rd_q.size() > 0) begin e = rd_q.pop_front(); exp_ret = e.port ? {2'b10, e.data, 8'h00} : {2'b01, 8'h00, e.data}; end
            n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== exp_ret) $display("[TB] FAIL basic_ret c%0d: got %h expected %h", c, {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, exp_ret); else n_pass++;
            n_checks++; if ({p1_gnt, p0_gnt} !== ((c < 2) ? 2'b01 : 2'b00)) $display("[TB] FAIL basic_gnt c%0d: got %b expected %b", c, {p1_gnt, p0_gnt}, (c < 2) ? 2'b01 : 2'b00); else n_pass++;
            if (c == 0) begin
                n_checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'h1F0, 8'hA5}) $display("[TB] FAIL basic_wr_bus: got %h expected %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 9'h1F0, 8'hA5}); else n_pass++;
                ref_mem[9'h1F0] = 8'hA5;
            end
            if (c == 1) begin
                n_checks++; if ({mem_we, mem_addr} !== {1'b0, 9'h1F0}) $display("[TB] FAIL basic_rd_bus: got %h expected %h", {mem_we, mem_addr}, {1'b0, 9'h1F0}); else n_pass++;
                rd_q.push_back('{port: 1'b0, data: ref_mem[9'h1F0]});
            end
        end
    endtask

    // Both ports read continuously; the bench model predicts every grant.
    task automatic test_priority(input int cycles, input logic do_reset_first);
        rd_t e;
        logic [17:0] exp_ret;
        logic exp_p1;
        if (do_reset_first) begin
            next_cycle(); set_idle(); rst = 1'b1;
            next_cycle(); rst = 1'b0;
            rd_q.delete(); scnt = 0; last_p1 = 1'b1;
        end
        for (int c = 0; c < cycles + 1; c++) begin
            next_cycle();
            set_idle();
            if (c < cycles) begin
                p0_req = 1'b1; p0_addr = 9'h010 + 9'(c);
                p1_req = 1'b1; p1_addr = 9'h020 + 9'(c);
            end
            @(negedge clk);
            exp_ret = '0;
            if (rd_q.size() > 0) begin e = rd_q.pop_front(); exp_ret = e.port ? {2'b10, e.data, 8'h00} : {2'b01, 8'h00, e.data}; end
            n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== exp_ret) $display("[TB] FAIL prio_ret c%0d: got %h expected %h", c, {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, exp_ret); else n_pass++;
            if (c < cycles) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                exp_p1 = ~last_p1;
                last_p1 = exp_p1;
`else
                exp_p1 = (scnt == MAX_BURST);
                if (exp_p1) scnt = 0;
                else if (scnt != MAX_BURST) scnt++;
`endif
                n_checks++; if ({p1_gnt, p0_gnt} !== {exp_p1, ~exp_p1}) $display("[TB] FAIL prio_gnt c%0d: got %b expected %b", c, {p1_gnt, p0_gnt}, {exp_p1, ~exp_p1}); else n_pass++;
                rd_q.push_back('{port: exp_p1, data: ref_mem[exp_p1 ? p1_addr : p0_addr]});
            end else begin
                scnt = 0;
            end
        end
    endtask

    task automatic test_alternate();
        rd_t e;
        logic [17:0] exp_ret;
        logic rd_p1;
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            set_idle();
            if (c < 4) begin p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'(c); p0_wdata = 8'h10 + 8'(c); end
            else if (c < 8) begin
                rd_p1 = ((c - 4) % 2) == 1;
                if (rd_p1) begin p1_req = 1'b1; p1_addr = 9'(c - 4); end
                else begin p0_req = 1'b1; p0_addr = 9'(c - 4); end
            end
            @(negedge clk);
            exp_ret = '0;
            if (rd_q.size() > 0) begin e = rd_q.pop_front(); exp_ret = e.port ? {2'b10, e.data, 8'h00} : {2'b01, 8'h00, e.data}; end
            n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== exp_ret) $display("[TB] FAIL alt_ret c%0d: got %h expected %h", c, {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, exp_ret); else n_pass++;
            if (c < 4) begin
                n_checks++; if ({p1_gnt, p0_gnt, mem_we} !== 3'b011) $display("[TB] FAIL alt_wr c%0d: got %b expected 011", c, {p1_gnt, p0_gnt, mem_we}); else n_pass++;
                ref_mem[c] = 8'h10 + 8'(c);
            end else if (c < 8) begin
                n_checks++; if ({p1_gnt, p0_gnt} !== {rd_p1, ~rd_p1}) $display("[TB] FAIL alt_gnt c%0d: got %b expected %b", c, {p1_gnt, p0_gnt}, {rd_p1, ~rd_p1}); else n_pass++;
                rd_q.push_back('{port: rd_p1, data: 8'h10 + 8'(c - 4)});
            end
        end
    endtask

    task automatic test_write_then_read();
        rd_t e;
        logic [17:0] exp_ret;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            set_idle();
            if (c == 0) begin p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h000; p1_wdata = 8'h3C; end
            if (c == 1) begin p0_req = 1'b1; p0_addr = 9'h000; end
            @(negedge clk);
            exp_ret = '0;
            if (rd_q.size() > 0) begin e = rd_q.pop_front(); exp_ret = e.port ? {2'b10, e.data, 8'h00} : {2'b01, 8'h00, e.data}; end
            n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== exp_ret) $display("[TB] FAIL wtr_ret c%0d: got %h expected %h", c, {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, exp_ret); else n_pass++;
            if (c == 0) begin
                n_checks++; if ({p1_gnt, p0_gnt, mem_we, mem_wdata} !== {3'b101, 8'h3C}) $display("[TB] FAIL wtr_wr: got %h expected %h", {p1_gnt, p0_gnt, mem_we, mem_wdata}, {3'b101, 8'h3C}); else n_pass++;
            end
            if (c == 1) begin
                n_checks++; if ({p1_gnt, p0_gnt} !== 2'b01) $display("[TB] FAIL wtr_rd_gnt: got %b expected 01", {p1_gnt, p0_gnt}); else n_pass++;
                rd_q.push_back('{port: 1'b0, data: 8'h3C});
            end
        end
        ref_mem[0] = 8'h3C;
        last_p1 = 1'b0;
        scnt = 0;
    endtask

    // Reset lands while a read is still in flight; the starvation count must start over afterwards.
    task automatic test_reset_drop();
        test_priority(3, 1'b0);
        next_cycle();
        set_idle();
        p0_req = 1'b1; p0_addr = 9'h011; p1_req = 1'b1; p1_addr = 9'h021;
        @(negedge clk);
        // a read from the previous cycle would be the last one in flight
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== 18'h0) $display("[TB] FAIL drop_ret: got %h expected 0", {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}); else n_pass++;
        n_checks++; if ({p1_gnt, p0_gnt, mem_we} !== 3'b000) $display("[TB] FAIL drop_gnt: got %b expected 000", {p1_gnt, p0_gnt, mem_we}); else n_pass++;
        n_checks++; if (mem_addr !== 9'h000) $display("[TB] FAIL drop_addr: got %h expected 000", mem_addr); else n_pass++;
        next_cycle();
        rst = 1'b0;
        set_idle();
        rd_q.delete();
        scnt = 0; last_p1 = 1'b1;
        @(negedge clk);
        n_checks++; if ({p1_rvalid, p0_rvalid} !== 2'b00) $display("[TB] FAIL drop_after: got %b expected 00", {p1_rvalid, p0_rvalid}); else n_pass++;
        test_priority(6, 1'b0);
    endtask

    task automatic test_idle_x();
        rd_t e;
        logic [17:0] exp_ret;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            set_idle();
            if (c == 0) begin p1_req = 1'b1; p1_addr = 9'h155; end
            else begin
                p0_we = 1'bx; p0_addr = 'x; p0_wdata = 'x;
                p1_we = 1'bx; p1_addr = 'x; p1_wdata = 'x;
            end
            @(negedge clk);
            exp_ret = '0;
            if (rd_q.size() > 0) begin e = rd_q.pop_front(); exp_ret = e.port ? {2'b10, e.data, 8'h00} : {2'b01, 8'h00, e.data}; end
            n_checks++; if ({p1_rvalid, p0_rvalid, p1_rdata, p0_rdata} !== exp_ret) $display("[TB] FAIL idle_ret c%0d: got %h expected %h", c, {p1_rvalid, p0_rvalid, p1_rdata, p0_rdata}, exp_ret); else n_pass++;
            if (c == 0) begin
                n_checks++; if ({p1_gnt, p0_gnt} !== 2'b10) $display("[TB] FAIL idle_rd_gnt: got %b expected 10", {p1_gnt, p0_gnt}); else n_pass++;
                rd_q.push_back('{port: 1'b1, data: ref_mem[9'h155]});
            end else begin
                n_checks++; if ({p1_gnt, p0_gnt, mem_we, mem_addr, mem_wdata} !== {3'b000, 9'h155, 8'h00}) $display("[TB] FAIL idle_bus c%0d: got %h expected %h", c, {p1_gnt, p0_gnt, mem_we, mem_addr, mem_wdata}, {3'b000, 9'h155, 8'h00}); else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        test_reset();
        test_basic_rw();
        test_priority(12, 1'b1);
        test_alternate();
        test_write_then_read();
        test_reset_drop();
        test_idle_x();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end
endmodule

// File: doc/mem_arb_2p.md
Name: mem_arb_2p

Overview:
- Two-requester arbiter in front of the 512x8 single-port RAM macro; shares one address/write/read path between port 0 (core) and port 1 (loader/debug).
- Default policy is fixed priority to port 0, with a starvation counter that forces a port 1 grant.
- Sequences the RAM's 1-cycle registered read and routes returned data back to the port that issued the read.

Parameters:
- AW, 9, address width; matches 512-entry RAM.
- DW, 8, data width.
- MAX_BURST, 4, max consecutive port 0 grants while port 1 waits; range 1..15.

Ports:
- i_clk  in  1  clock; all logic on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_p0_req  in  1  port 0 access request; held until granted.
- i_p0_we  in  1  port 0 write (1) / read (0).
- i_p0_addr  in  AW  port 0 address.
- i_p0_wdata  in  DW  port 0 write data.
- o_p0_gnt  out  1  port 0 granted this cycle (combinational).
- o_p0_rvalid  out  1  port 0 read data valid.
- o_p0_rdata  out  DW  port 0 read data.
- i_p1_req, i_p1_we, i_p1_addr, i_p1_wdata, o_p1_gnt, o_p1_rvalid, o_p1_rdata: same as port 0, for port 1.
- o_mem_addr  out  AW  to RAM i_addr.
- o_mem_we  out  1  to RAM i_we.
- o_mem_wdata  out  DW  to RAM i_wdata.
- i_mem_rdata  in  DW  from RAM o_rdata; valid the cycle after the address was presented.

Behaviour:
- Grant is combinational, same cycle as the request. At most one gnt is high per cycle. A request completes on the cycle its gnt is high; the requester may change inputs on the next cycle.
- Fixed priority:
  - Only p0 requests: p0 granted.
  - Only p1 requests: p1 granted.
  - Both request: p0 granted unless starve_cnt == MAX_BURST, in which case p1 is granted.
- starve_cnt (4-bit):
  - Increments when p0 is granted while p1 requests.
  - Clears when p1 is granted or p1 does not request.
  - Saturates at MAX_BURST.
- Mux: o_mem_addr/we/wdata come from the granted port. With no grant: addr holds its last value, we=0, wdata=0. o_mem_we = gnt & we of the granted port.
- Read return pipeline (one stage): registers rd_owner (2-bit one-hot) = {p1_gnt & ~p1_we, p0_gnt & ~p0_we}.
  - o_pN_rvalid = rd_owner[N], high exactly 1 cycle after a granted read.
  - o_pN_rdata = i_mem_rdata when rd_owner[N] is set, else 0.
- Back-to-back granted reads, including alternating ports, give one rvalid per cycle with no bubbles.
- A write granted in cycle N followed by a read of the same address granted in N+1 returns the new data (RAM write-first ordering).
- Reset (i_rst=1 on a posedge):
  - rd_owner=0, starve_cnt=0, last-grant=p1 (so round-robin starts with p0), held addr=0.
  - o_pN_rvalid=0 and o_pN_rdata=0 from the next cycle.
  - Gnt outputs are forced 0 while i_rst is high.
  - A read in flight at reset is dropped: no rvalid is produced.
- Requests with X on we/addr while req=0 must not affect any output.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request, grant the port not granted last time, using a 1-bit last-grant register updated on every grant. starve_cnt and MAX_BURST are unused.
- Undefined: fixed priority plus starvation counter as above. The single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then p0 write 0xA5 @0x1F0, then p0 read 0x1F0 -> o_p0_gnt high both cycles; o_p0_rvalid=1 with o_p0_rdata=0xA5 one cycle after the read grant; p1 outputs stay 0.
- p0 and p1 request reads continuously, MAX_BURST=4 -> grant pattern p0,p0,p0,p0,p1 repeating. With MEM_ARB_ROUND_ROBIN_EN the pattern is p0,p1,p0,p1.
- Preload 0x00..0x03 with 0x10..0x13; alternating granted reads p0@0, p1@1, p0@2, p1@3 -> rvalid alternates every cycle with data 0x10, 0x11, 0x12, 0x13 routed to the correct port.
- p1 writes 0x3C @0x000 in cycle N; p0 reads 0x000 in N+1 -> o_p0_rdata=0x3C in N+2.
- p0 read granted, then i_rst=1 in the following cycle -> no o_p0_rvalid; all outputs 0 during reset; starve_cnt restarts at 0.
- Idle cycles with req=0 and X on the address/data inputs -> o_mem_we=0, no gnt, no rvalid, and o_mem_addr holds its prior value.
